// File: rtl/kbd_pkg.sv
// kbd_pkg
// Shared constants and helpers for the key matrix scanner.
//   COL_ON / COL_OFF : column drive levels (columns are active-low)
//   key_index()      : flat key number for a (row, column) pair
//   cnt_width()      : width of a counter that must hold 0..debounce
package kbd_pkg;

  localparam logic COL_ON  = 1'b0;
  localparam logic COL_OFF = 1'b1;

  // Keys are numbered row-major so that one row of the matrix occupies a
  // contiguous run of bits in the output vectors.
  function automatic int key_index(input int r, input int c, input int n_cols);
    return r * n_cols + c;
  endfunction

  function automatic int cnt_width(input int debounce);
    return $clog2(debounce + 1);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce
// Debounces one key of the matrix and derives its level, toggle and pulse.
//   aclk, aresetn : clock and asynchronous active-low reset
//   sample_en     : one-cycle strobe when this key's column is sampled
//   sample        : synchronised key level at that strobe, 1 = pressed
//   clear_save    : synchronous clear of the toggle latch
//   o_push        : debounced level, 1 = pressed
//   o_save        : toggles on every debounced press
//   o_press       : one-cycle pulse on every debounced press
module key_debounce
  import kbd_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic sample_en,
  input  logic sample,
  input  logic clear_save,
  output logic o_push,
  output logic o_save,
  output logic o_press
);

  localparam int CW = cnt_width(DEBOUNCE);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic [CW-1:0] cnt;

  // cnt counts consecutive samples that disagree with the stable level.
  // The DEBOUNCE-th disagreeing sample flips the level instead of counting,
  // so with DEBOUNCE=1 the first differing sample flips immediately.
  // The clear is applied last so it overrides a toggle on the same edge,
  // while the press pulse is still emitted.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt     <= '0;
      o_push  <= 1'b0;
      o_save  <= 1'b0;
      o_press <= 1'b0;
    end else begin
      o_press <= 1'b0;
      if (sample_en) begin
        if (sample == o_push) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          cnt    <= '0;
          o_push <= sample;
          if (sample) begin
            o_press <= 1'b1;
            o_save  <= ~o_save;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      if (clear_save) begin
        o_save <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/button_matrix_scanner.sv
// button_matrix_scanner
// Scans an N_ROWS x N_COLS key matrix one column at a time and debounces
// every key independently.
//   aclk, aresetn  : clock and asynchronous active-low reset
//   O_BUTTON_COL   : column drive, active-low one-hot
//   I_BUTTON_ROW   : row sense, active-low, asynchronous to aclk
//   i_clear_save   : synchronous clear of all save bits
//   o_key_push     : debounced level per key (k = r*N_COLS + c)
//   o_key_save     : per-key toggle latch
//   o_key_press    : per-key one-cycle press pulse
module button_matrix_scanner
  import kbd_pkg::*;
#(
  parameter int N_ROWS   = 4,
  parameter int N_COLS   = 3,
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 4,
  localparam int K       = N_ROWS * N_COLS
) (
  input  logic              aclk,
  input  logic              aresetn,
  output logic [N_COLS-1:0] O_BUTTON_COL,
  input  logic [N_ROWS-1:0] I_BUTTON_ROW,
  input  logic              i_clear_save,
  output logic [K-1:0]      o_key_push,
  output logic [K-1:0]      o_key_save,
  output logic [K-1:0]      o_key_press
);

  localparam int DW  = $clog2(SCAN_DIV);
  localparam int CLW = $clog2(N_COLS);
  localparam logic [DW-1:0]  DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CLW-1:0] COL_LAST = CLW'(N_COLS - 1);

  logic [N_ROWS-1:0] row_meta;
  logic [N_ROWS-1:0] row_sync;
  logic [N_ROWS-1:0] row_pressed;
  logic [DW-1:0]     div_q;
  logic [CLW-1:0]    col_q;
  logic              tick;

  // Two-flop synchroniser. Resetting to 0 reads as "pressed" after the
  // inversion, but the first sampling tick is SCAN_DIV-1 >= 3 cycles away,
  // by which time both flops hold real pin values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      row_meta <= '0;
      row_sync <= '0;
    end else begin
      row_meta <= I_BUTTON_ROW;
      row_sync <= row_meta;
    end
  end

  assign row_pressed = ~row_sync;
  assign tick        = (div_q == DIV_LAST);

  // The divider wraps on every tick and the column advances on that same
  // edge, so the rows are always sampled SCAN_DIV-1 cycles after the column
  // changed, leaving the synchroniser and the matrix wiring time to settle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      div_q <= '0;
      col_q <= '0;
    end else if (tick) begin
      div_q <= '0;
      col_q <= (col_q == COL_LAST) ? '0 : col_q + 1'b1;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // Gating with aresetn keeps every column released while in reset and lets
  // column 0 appear in the very first cycle after reset lifts, so column 0
  // is driven for its full SCAN_DIV cycles like every other column.
  always_comb begin
    O_BUTTON_COL = {N_COLS{COL_OFF}};
    for (int c = 0; c < N_COLS; c++) begin
      if (aresetn && (col_q == CLW'(c))) begin
        O_BUTTON_COL[c] = COL_ON;
      end
    end
  end

  // One debouncer per key; a key only sees a sample when its own column is
  // the active one at the tick.
  for (genvar r = 0; r < N_ROWS; r++) begin : g_row
    for (genvar c = 0; c < N_COLS; c++) begin : g_col
      localparam int KI = key_index(r, c, N_COLS);

      logic sample_en;
      assign sample_en = tick && (col_q == CLW'(c));

      key_debounce #(
        .DEBOUNCE(DEBOUNCE)
      ) u_key (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .sample_en (sample_en),
        .sample    (row_pressed[r]),
        .clear_save(i_clear_save),
        .o_push    (o_key_push[KI]),
        .o_save    (o_key_save[KI]),
        .o_press   (o_key_press[KI])
      );
    end
  end

endmodule

// File: tb/tb_button_matrix_scanner.sv
// tb_button_matrix_scanner
// Drives a simulated key matrix (a set of held keys pulls a row low while
// its column is driven) and compares the scanner against a per-key model
// built from the scan and debounce rules, every cycle.
module tb_button_matrix_scanner;

  localparam int N_ROWS   = 4;
  localparam int N_COLS   = 3;
  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 2;
  localparam int K        = N_ROWS * N_COLS;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic [N_COLS-1:0] O_BUTTON_COL;
  logic [N_ROWS-1:0] I_BUTTON_ROW;
  logic              i_clear_save;
  logic [K-1:0]      o_key_push;
  logic [K-1:0]      o_key_save;
  logic [K-1:0]      o_key_press;

  always #5 aclk = ~aclk;

  button_matrix_scanner #(
    .N_ROWS  (N_ROWS),
    .N_COLS  (N_COLS),
    .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE(DEBOUNCE)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .O_BUTTON_COL(O_BUTTON_COL),
    .I_BUTTON_ROW(I_BUTTON_ROW),
    .i_clear_save(i_clear_save),
    .o_key_push  (o_key_push),
    .o_key_save  (o_key_save),
    .o_key_press (o_key_press)
  );

  int errorCount = 0;
  int checkCount = 0;

  // keys currently held down on the simulated board
  logic [K-1:0] keySet;

  // reference model state
  int           mDiv;
  int           mCol;
  int           mCount [K];
  logic [K-1:0] mStable;
  logic [K-1:0] mSave;
  logic [K-1:0] mPress;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    mDiv    = 0;
    mCol    = 0;
    mStable = '0;
    mSave   = '0;
    mPress  = '0;
    for (int k = 0; k < K; k++) mCount[k] = 0;
  endtask

  // One clock edge of the scanner as seen from outside: every SCAN_DIV-th
  // edge samples the keys of the active column and moves to the next one.
  task automatic modelEdge(input logic clr);
    mPress = '0;
    if (mDiv == SCAN_DIV - 1) begin
      for (int r = 0; r < N_ROWS; r++) begin
        int k = r * N_COLS + mCol;
        if (keySet[k] == mStable[k]) begin
          mCount[k] = 0;
        end else begin
          mCount[k] = mCount[k] + 1;
          if (mCount[k] == DEBOUNCE) begin
            mCount[k]  = 0;
            mStable[k] = keySet[k];
            if (keySet[k]) begin
              mPress[k] = 1'b1;
              mSave[k]  = ~mSave[k];
            end
          end
        end
      end
      mCol = (mCol + 1) % N_COLS;
      mDiv = 0;
    end else begin
      mDiv = mDiv + 1;
    end
    if (clr) mSave = '0;
  endtask

  // A row reads low when a held key sits in that row of the driven column.
  task automatic driveRows();
    logic [N_ROWS-1:0] rows;
    for (int r = 0; r < N_ROWS; r++) rows[r] = ~keySet[r * N_COLS + mCol];
    I_BUTTON_ROW = rows;
  endtask

  task automatic checkAll();
    logic [N_COLS-1:0] expCol;
    expCol = '1;
    if (aresetn) expCol[mCol] = 1'b0;
    checkOutput("col",   32'(O_BUTTON_COL), 32'(expCol));
    checkOutput("push",  32'(o_key_push),   32'(mStable));
    checkOutput("save",  32'(o_key_save),   32'(mSave));
    checkOutput("press", 32'(o_key_press),  32'(mPress));
  endtask

  task automatic stepCycle(input logic clr);
    i_clear_save = clr;
    @(posedge aclk);
    modelEdge(clr);
    #1;
    checkAll();
    driveRows();
  endtask

  // Holds 'keys' for ncols whole column periods. clrMode 1 raises the clear
  // on every column-0 sampling edge, clrMode 2 raises it at random.
  task automatic applyStimulus(input logic [K-1:0] keys, input int ncols, input int clrMode);
    logic clr;
    keySet = keys;
    driveRows();
    for (int i = 0; i < ncols * SCAN_DIV; i++) begin
      clr = 1'b0;
      if (clrMode == 1 && mDiv == SCAN_DIV - 1 && mCol == 0) clr = 1'b1;
      if (clrMode == 2 && $urandom_range(0, 15) == 0) clr = 1'b1;
      stepCycle(clr);
    end
  endtask

  task automatic resetDut();
    aresetn      = 1'b0;
    i_clear_save = 1'b0;
    modelReset();
    #1;
    checkAll();
    repeat (2) @(posedge aclk);
    #1;
    checkAll();
    aresetn = 1'b1;
    #1;
    checkAll();
    driveRows();
  endtask

  initial begin
    aresetn      = 1'b0;
    i_clear_save = 1'b0;
    keySet       = '0;
    I_BUTTON_ROW = '1;
    modelReset();
    #2;

    // reset and column walk
    resetDut();
    checkOutput("walk_start", 32'(O_BUTTON_COL), 32'(3'b110));
    applyStimulus('0, 1, 0);
    checkOutput("walk_col1", 32'(O_BUTTON_COL), 32'(3'b101));
    applyStimulus('0, 1, 0);
    checkOutput("walk_col2", 32'(O_BUTTON_COL), 32'(3'b011));
    applyStimulus('0, 1, 0);
    checkOutput("walk_wrap", 32'(O_BUTTON_COL), 32'(3'b110));

    // bounce rejection: key 7 held across a single column-1 sample only
    applyStimulus(12'h080, 2, 0);
    applyStimulus(12'h000, 1, 0);
    applyStimulus(12'h000, 3, 0);
    checkOutput("bounce_push", 32'(o_key_push), 32'h0);
    checkOutput("bounce_save", 32'(o_key_save), 32'h0);

    // single press of key 7 (row 2, column 1)
    applyStimulus(12'h080, 3, 0);
    checkOutput("press7_early", 32'(o_key_push), 32'h0);
    applyStimulus(12'h080, 2, 0);
    checkOutput("press7_pulse", 32'(o_key_press), 32'h080);
    checkOutput("press7_push", 32'(o_key_push), 32'h080);
    applyStimulus(12'h080, 1, 0);
    checkOutput("press7_pulse_end", 32'(o_key_press), 32'h0);
    checkOutput("press7_save", 32'(o_key_save), 32'h080);

    // release then second press toggles save back
    applyStimulus(12'h000, 6, 0);
    checkOutput("release7_push", 32'(o_key_push), 32'h0);
    checkOutput("release7_save", 32'(o_key_save), 32'h080);
    applyStimulus(12'h080, 6, 0);
    checkOutput("second7_save", 32'(o_key_save), 32'h0);
    applyStimulus(12'h000, 6, 0);

    // simultaneous keys 0 and 11, then clear coinciding with a press
    applyStimulus(12'h801, 6, 0);
    checkOutput("multi_push", 32'(o_key_push), 32'h801);
    checkOutput("multi_save", 32'(o_key_save), 32'h801);
    applyStimulus(12'h800, 6, 0);
    applyStimulus(12'h801, 3, 0);
    applyStimulus(12'h801, 1, 1);
    checkOutput("clear_press0", 32'(o_key_press), 32'h001);
    checkOutput("clear_save", 32'(o_key_save), 32'h0);
    applyStimulus(12'h000, 6, 0);

    // reset in the middle of a debounce
    applyStimulus(12'h080, 2, 0);
    resetDut();
    checkOutput("midreset_push", 32'(o_key_push), 32'h0);
    applyStimulus(12'h080, 3, 0);
    checkOutput("midreset_one_tick", 32'(o_key_push), 32'h0);
    applyStimulus(12'h080, 3, 0);
    checkOutput("midreset_two_ticks", 32'(o_key_push), 32'h080);

    // random key sets, random clears, occasional resets
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 24) == 0) resetDut();
      applyStimulus(K'($urandom & $urandom), int'($urandom_range(1, 4)), 2);
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/button_matrix_scanner.md
# button_matrix_scanner

Parametrised successor to the fixed 3x4 button manager. It scans an N_ROWS x N_COLS key matrix by driving one column at a time and sampling the row inputs. Each key is debounced independently. Per key it outputs the debounced level (push), a toggle latch (save) with a synchronous clear, and a one-cycle press pulse. It sits between the board's column/row pins and consumers such as the 8x8 LED and colour-LED managers.

## Interface
- N_ROWS, 4: row input count (>=1).
- N_COLS, 3: column output count (>=2).
- SCAN_DIV, 50000: aclk cycles each column stays driven (>=4).
- DEBOUNCE, 4: consecutive agreeing samples needed to change a key's state (>=1).
- K: localparam, N_ROWS*N_COLS. Key index k = r*N_COLS + c.

- aclk  in  1: single clock.
- aresetn  in  1: asynchronous, active-low reset.
- O_BUTTON_COL  out  N_COLS: column drive, active-low one-hot.
- I_BUTTON_ROW  in  N_ROWS: row sense, active-low, asynchronous to aclk.
- i_clear_save  in  1: synchronous clear of all save bits.
- o_key_push  out  K: debounced pressed level, 1 = pressed.
- o_key_save  out  K: toggles on each debounced press.
- o_key_press  out  K: one-cycle pulse on each debounced press.

## Operation
- **Row synchroniser:** I_BUTTON_ROW passes through a 2-flop synchroniser, then is inverted so 1 = pressed.
- **Column sequence:** a column counter walks 0..N_COLS-1 and wraps to 0. O_BUTTON_COL drives the active column 0 and all others 1.
- **Column timing:** a divider counts 0..SCAN_DIV-1 while a column is active.
  - On divider = SCAN_DIV-1 (the "tick"), the synchronised rows are sampled for the active column.
  - The column advances on the same edge.
- **Per-key debounce:** each key holds a stable state S and a counter C of width clog2(DEBOUNCE+1).
  - On that key's tick, if sample == S, C is cleared.
  - Otherwise C increments. When C+1 == DEBOUNCE, S flips and C clears.
- **Outputs:**
  - o_key_push = S.
  - On an S transition 0->1, o_key_press pulses for one cycle and save toggles.
  - An S transition 1->0 produces no pulse.
- **Clear:** i_clear_save=1 zeros all save bits. If clear and a press occur in the same cycle, clear wins (save=0) and the press pulse is still emitted.
- **Multiple keys:** any number of keys may be pressed at once. Each is tracked independently; ghosting is not compensated.

## Timing
- **Reset values:**
  - O_BUTTON_COL all 1s.
  - Column counter and divider 0.
  - All S, C, save and press 0.
  - Synchroniser flops 0, i.e. "pressed" after inversion. This is harmless because no tick can occur before the flops have refilled.
- **First cycle after aresetn rises:** column 0 is driven.
- **Scan rates:** column period is SCAN_DIV cycles; frame period is N_COLS*SCAN_DIV cycles.
- **Settling margin:** rows are sampled SCAN_DIV-1 cycles after the column change, which covers the synchroniser's 2 cycles plus settling.
- **Press latency:** push/save/press change on the rising edge at the DEBOUNCE-th consecutive differing tick. They are registered, so visible the cycle after that tick.
- **Release latency:** same rule as press latency.
- **Counter wrap:** the column counter wraps N_COLS-1 -> 0 with no idle cycle. The divider wraps on every tick.
- **Reset mid-operation:** all state returns to reset values immediately (asynchronous), and any in-progress debounce count is lost.
- **DEBOUNCE=1:** the state flips on the first differing sample.

## Structure
- **Package `kbd_pkg`:**
  - function key_index(r, c) returning r*N_COLS + c.
  - function clog2-based counter width.
  - Active-level constants COL_ON=0, COL_OFF=1.
- **Sub-module `key_debounce`:**
  - Parameter DEBOUNCE.
  - Ports: aclk, aresetn, sample_en, sample, clear_save, o_push, o_save, o_press.
  - Instantiated K times via generate.
  - sample_en is driven by tick AND (active column == c).
- **Top level:** divider, column counter, synchroniser and generate loop.

## Test plan
Parameters for all scenarios: N_ROWS=4, N_COLS=3, SCAN_DIV=4, DEBOUNCE=2.
- **Reset and column walk:** hold aresetn=0 -> O_BUTTON_COL=3'b111, all outputs 0. Release reset -> 3'b110 for 4 cycles, then 3'b101, then 3'b011, then 3'b110 (wrap).
- **Single press:** pull row 2 low whenever column 1 is active (k=7) -> o_key_push[7]=1 and o_key_press[7] a single-cycle pulse, one cycle after the 2nd col-1 tick; o_key_save[7]=1; no other bits change.
- **Bounce rejection:** key 7 pressed for exactly one col-1 tick, then released -> push, save and press stay 0. Next frame press again -> the counter restarts and needs 2 ticks.
- **Second press and release:** release key 7 for 2 frames -> push[7]=0, no pulse. Press key 7 again -> save[7] returns to 0.
- **Simultaneous keys and clear:**
  - Press k=0 and k=11 together -> both push bits set after 2 frames.
  - Assert i_clear_save in the cycle of k=0's press pulse -> save=0 for all keys; press[0] still pulses.
- **Reset mid-debounce:** assert aresetn=0 after 1 of 2 ticks of a press -> all outputs 0. After release, 2 fresh ticks are required.
